muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: iterative 32-cycle shift-add multiply and restoring divide,
// with single-cycle fast paths for divide-by-zero and signed overflow.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [2:0]  funct3,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned CW   = 5;
    localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_q, state_nxt;
    logic [CW-1:0]     cnt_q;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   hi_q, lo_q, dvs_q;
    logic              a_neg_q, b_neg_q;

    logic              busy_nxt, done_nxt, res_load;
    logic [XLEN-1:0]   res_nxt;

    // operand decode at the accepting edge
    logic              accept, a_signed, b_signed, a_neg, b_neg;
    logic              div_zero, div_ovf, fast;
    logic [XLEN-1:0]   mag_a, mag_b, fast_res;

    assign accept   = start && (state_q != CALC);
    assign a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign a_neg    = a_signed && src_a[XLEN-1];
    assign b_neg    = b_signed && src_b[XLEN-1];
    assign mag_a    = a_neg ? XLEN'(-src_a) : src_a;
    assign mag_b    = b_neg ? XLEN'(-src_b) : src_b;
    assign div_zero = funct3[2] && (src_b == '0);
    assign div_ovf  = funct3[2] && !funct3[0] && (src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF);
    assign fast     = div_zero || div_ovf;
    assign fast_res = div_zero ? (funct3[1] ? src_a : 32'hFFFF_FFFF)
                               : (funct3[1] ? 32'h0000_0000 : 32'h8000_0000);

    // one iteration: hi/lo hold product halves (multiply) or remainder/quotient (divide)
    logic [XLEN:0]     mul_sum, div_sh, div_diff;
    logic [2*XLEN-1:0] mul_sh;
    logic              div_ge;
    logic [XLEN-1:0]   hi_step, lo_step;

    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvs_q} : (XLEN+1)'(0));
        mul_sh   = {mul_sum, lo_q[XLEN-1:1]};
        div_sh   = {hi_q, lo_q[XLEN-1]};
        div_diff = div_sh - {1'b0, dvs_q};
        div_ge   = !div_diff[XLEN];
        if (op_q[2]) begin
            hi_step = div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
            lo_step = {lo_q[XLEN-2:0], div_ge};
        end else begin
            hi_step = mul_sh[2*XLEN-1:XLEN];
            lo_step = mul_sh[XLEN-1:0];
        end
    end

    // sign fix-up of the final iteration's outcome
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, calc_res;

    always_comb begin
        prod_s   = (a_neg_q ^ b_neg_q) ? (2*XLEN)'(-{hi_step, lo_step}) : {hi_step, lo_step};
        quo_s    = (a_neg_q ^ b_neg_q) ? XLEN'(-lo_step) : lo_step;
        rem_s    = a_neg_q ? XLEN'(-hi_step) : hi_step;
        if (op_q[2])
            calc_res = op_q[1] ? rem_s : quo_s;
        else
            calc_res = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE, DONE: state_nxt = start ? (fast ? DONE : CALC) : IDLE;
            CALC:       if (cnt_q == LAST_ITER) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_nxt = (state_nxt == CALC);
        done_nxt = (state_nxt == DONE);
        res_load = 1'b0;
        res_nxt  = result;
        if (accept && fast) begin
            res_load = 1'b1;
            res_nxt  = fast_res;
        end else if ((state_q == CALC) && (cnt_q == LAST_ITER)) begin
            res_load = 1'b1;
            res_nxt  = calc_res;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dvs_q   <= '0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            result  <= '0;
        end else begin
            if (accept) begin
                cnt_q   <= '0;
                op_q    <= funct3;
                hi_q    <= '0;
                lo_q    <= mag_a;
                dvs_q   <= mag_b;
                a_neg_q <= a_neg;
                b_neg_q <= b_neg;
            end else if (state_q == CALC) begin
                cnt_q   <= cnt_q + CW'(1);
                hi_q    <= hi_step;
                lo_q    <= lo_step;
            end
            if (res_load)
                result <= res_nxt;
        end
    end

endmodule
